// File: rtl/keyseq_gen.sv
// Bus-mapped challenge/response key sequencer built around a Fibonacci-style LFSR.
// Optional brute-force lockout is compiled in by defining KEYSEQ_LOCKOUT_EN.
module keyseq_gen #(
   parameter int unsigned        STATE_W     = 6,
   parameter int unsigned        ADDR_W      = 14,
   parameter logic [1:0]         WIN_SEL     = 2'b01,
   parameter logic [STATE_W-1:0] SEED        = 6'h2D,
   parameter logic [STATE_W-1:0] POLY        = 6'h30,
   parameter logic [STATE_W-1:0] OUT_TAPS    = 6'h29,
   parameter logic [3:0]         KEY_XOR     = 4'h0,
   parameter int unsigned        UNLOCK_LEN  = 8,
   parameter int unsigned        LOCK_CYCLES = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_W-1:0]  bus_addr,
   input  logic               bus_cs_n,
   input  logic               bus_rd,
   input  logic               bus_strobe,
   output logic               sdrd,
   output logic               sdrd_oe,
   output logic               unlocked,
   output logic               locked_out,
   output logic [STATE_W-1:0] state_q
);

   typedef enum logic [1:0] {
      StIdle,
      StTrack,
      StUnlocked
`ifdef KEYSEQ_LOCKOUT_EN
      , StLockout
`endif
   } fsm_e;

   fsm_e               fsm;
   logic [STATE_W-1:0] lfsr;
   logic [STATE_W-1:0] lfsr_next;
   logic [7:0]         step;
   logic [7:0]         step_inc;
   logic               qa;
   logic [3:0]         nib;
   logic               match;
   logic               relock;
   logic               resp;
   logic               in_lockout;

   always_comb begin
      qa        = bus_strobe & ~bus_cs_n & bus_rd & (bus_addr[ADDR_W-1 -: 2] == WIN_SEL);
      nib       = bus_addr[7:4];
      match     = (nib == (lfsr[3:0] ^ KEY_XOR));
      relock    = (nib == 4'hF);
      resp      = ^(lfsr & OUT_TAPS);
      lfsr_next = {lfsr[STATE_W-2:0], ^(lfsr & POLY)};
      step_inc  = (step == 8'hFF) ? step : step + 8'd1;
   end

   assign state_q = lfsr;

`ifdef KEYSEQ_LOCKOUT_EN
   localparam int unsigned TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

   logic [1:0]    fail_cnt;
   logic [TW-1:0] lock_timer;

   assign in_lockout = (fsm == StLockout);
`else
   localparam int unsigned unused_lock_cycles = LOCK_CYCLES;

   assign in_lockout = 1'b0;
   assign locked_out = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm      <= StIdle;
         lfsr     <= SEED;
         step     <= 8'd0;
         sdrd     <= 1'b0;
         sdrd_oe  <= 1'b0;
         unlocked <= 1'b0;
`ifdef KEYSEQ_LOCKOUT_EN
         fail_cnt   <= 2'd0;
         lock_timer <= '0;
         locked_out <= 1'b0;
`endif
      end else begin
         // Every qualified access gets a response bit, whatever the state.
         sdrd_oe <= qa;
         sdrd    <= qa & resp & ~in_lockout;
         if (qa) begin
            case (fsm)
               StIdle, StTrack: begin
                  if (match) begin
                     lfsr <= lfsr_next;
                     step <= step_inc;
                     if (step_inc >= 8'(UNLOCK_LEN)) begin
                        fsm      <= StUnlocked;
                        unlocked <= 1'b1;
`ifdef KEYSEQ_LOCKOUT_EN
                        fail_cnt <= 2'd0;
`endif
                     end else begin
                        fsm <= StTrack;
                     end
                  end else begin
                     lfsr <= SEED;
                     step <= 8'd0;
                     fsm  <= StIdle;
`ifdef KEYSEQ_LOCKOUT_EN
                     if (fail_cnt != 2'd3) fail_cnt <= fail_cnt + 2'd1;
                     if (fail_cnt >= 2'd2) begin
                        fsm        <= StLockout;
                        locked_out <= 1'b1;
                        lock_timer <= TW'(LOCK_CYCLES - 1);
                     end
`endif
                  end
               end
               StUnlocked: begin
                  if (relock) begin
                     lfsr     <= SEED;
                     step     <= 8'd0;
                     fsm      <= StIdle;
                     unlocked <= 1'b0;
`ifdef KEYSEQ_LOCKOUT_EN
                     fail_cnt <= 2'd0;
`endif
                  end else begin
                     lfsr <= lfsr_next;
                  end
               end
               default: ;
            endcase
         end
`ifdef KEYSEQ_LOCKOUT_EN
         // Lockout runs for exactly LOCK_CYCLES cycles after the deciding access.
         if (fsm == StLockout) begin
            if (lock_timer == '0) begin
               fsm        <= StIdle;
               locked_out <= 1'b0;
               fail_cnt   <= 2'd0;
            end else begin
               lock_timer <= lock_timer - 1'b1;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_keyseq_gen.sv
// Scoreboard bench for keyseq_gen: stimulus pushes hand-computed expectations, a
// negedge monitor pops one per sdrd_oe pulse. Lockout cases need KEYSEQ_LOCKOUT_EN.
module tb_keyseq_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic [13:0] bus_addr;
   logic        bus_cs_n;
   logic        bus_rd;
   logic        bus_strobe;
   logic        sdrd;
   logic        sdrd_oe;
   logic        unlocked;
   logic        locked_out;
   logic [5:0]  state_q;

   typedef struct packed {
      logic       sdrd;
      logic [5:0] st;
      logic       unl;
      logic       lck;
   } exp_t;

   exp_t exp_q[$];
   exp_t got;
   exp_t want;
   int   tests = 0;
   int   fails = 0;

   keyseq_gen #(.LOCK_CYCLES(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus_addr   (bus_addr),
      .bus_cs_n   (bus_cs_n),
      .bus_rd     (bus_rd),
      .bus_strobe (bus_strobe),
      .sdrd       (sdrd),
      .sdrd_oe    (sdrd_oe),
      .unlocked   (unlocked),
      .locked_out (locked_out),
      .state_q    (state_q)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (sdrd_oe) begin
         tests++;
         got = '{sdrd: sdrd, st: state_q, unl: unlocked, lck: locked_out};
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_resp got %p required no response", got);
         end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
               fails++;
               $display("FAIL resp got %p required %p", got, want);
            end
         end
      end else if (sdrd !== 1'b0) begin
         tests++;
         fails++;
         $display("FAIL sdrd_idle got %b required 0", sdrd);
      end
   end

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s got %0h required %0h", name, act, req);
      end
   endtask

   task automatic drive(input logic [1:0] win, input logic [3:0] nib, input logic cs_n,
                        input logic rd);
      @(posedge clk);
      #1;
      bus_addr   = {win, 4'h0, nib, 4'h0};
      bus_cs_n   = cs_n;
      bus_rd     = rd;
      bus_strobe = 1'b1;
   endtask

   // Qualified read plus the response the DUT must give one cycle later.
   task automatic qacc(input logic [3:0] nib, input logic e_sdrd, input logic [5:0] e_st,
                       input logic e_unl, input logic e_lck);
      drive(2'b01, nib, 1'b0, 1'b1);
      exp_q.push_back('{sdrd: e_sdrd, st: e_st, unl: e_unl, lck: e_lck});
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      bus_strobe = 1'b0;
      bus_rd     = 1'b0;
      bus_cs_n   = 1'b1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst        = 1'b1;
      bus_strobe = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   logic [3:0] u_nib [8] = '{4'hD, 4'hB, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6, 4'hC};
   logic [5:0] u_st  [8] = '{6'h1B, 6'h37, 6'h2E, 6'h1D, 6'h3B, 6'h36, 6'h2C, 6'h19};
   logic       u_r   [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

   initial begin
      int cnt;
      rst        = 1'b1;
      bus_addr   = '0;
      bus_cs_n   = 1'b1;
      bus_rd     = 1'b0;
      bus_strobe = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_state_q", state_q, 6'h2D);
      check("reset_sdrd_oe", sdrd_oe, 0);
      check("reset_unlocked", unlocked, 0);
      check("reset_locked_out", locked_out, 0);

      // First challenge, second, then a wrong nibble restarts at SEED.
      qacc(4'hD, 1'b1, 6'h1B, 1'b0, 1'b0);
      qacc(4'hB, 1'b0, 6'h37, 1'b0, 1'b0);
      qacc(4'h0, 1'b0, 6'h2D, 1'b0, 1'b0);
      idle();
      do_reset();

      // Reset wins over a simultaneous access and discards progress.
      qacc(4'hD, 1'b1, 6'h1B, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus_addr = {2'b01, 4'h0, 4'hB, 4'h0};
      @(posedge clk);
      #1;
      rst        = 1'b0;
      bus_strobe = 1'b0;
      check("rst_prio_state_q", state_q, 6'h2D);
      check("rst_prio_sdrd_oe", sdrd_oe, 0);

      // Back-to-back unlock sequence, free-run, then relock.
      for (int i = 0; i < 8; i++) qacc(u_nib[i], u_r[i], u_st[i], (i == 7), 1'b0);
      qacc(4'h0, 1'b0, 6'h33, 1'b1, 1'b0);
      qacc(4'h5, 1'b0, 6'h26, 1'b1, 1'b0);
      qacc(4'h3, 1'b1, 6'h0D, 1'b1, 1'b0);
      qacc(4'hF, 1'b0, 6'h2D, 1'b0, 1'b0);
      qacc(4'hD, 1'b1, 6'h1B, 1'b0, 1'b0);
      idle();
      do_reset();

      // Write cycle, deselected chip, wrong window: all ignored.
      drive(2'b01, 4'hD, 1'b0, 1'b0);
      drive(2'b01, 4'hD, 1'b1, 1'b1);
      drive(2'b10, 4'hD, 1'b0, 1'b1);
      idle();
      check("ignored_state_q", state_q, 6'h2D);
      check("ignored_sdrd_oe", sdrd_oe, 0);
      qacc(4'hD, 1'b1, 6'h1B, 1'b0, 1'b0);
      idle();
      do_reset();

`ifdef KEYSEQ_LOCKOUT_EN
      qacc(4'h0, 1'b1, 6'h2D, 1'b0, 1'b0);
      qacc(4'h0, 1'b1, 6'h2D, 1'b0, 1'b0);
      qacc(4'h0, 1'b1, 6'h2D, 1'b0, 1'b1);
      qacc(4'hD, 1'b0, 6'h2D, 1'b0, 1'b1);
      idle();
      // locked_out has been high for two edges at this point.
      cnt = 2;
      for (int i = 0; i < 100 && locked_out; i++) begin
         @(posedge clk);
         #1;
         if (locked_out) cnt++;
      end
      check("lockout_cycles", cnt, 16);
      qacc(4'hD, 1'b1, 6'h1B, 1'b0, 1'b0);
      idle();
`else
      cnt = 0;
      qacc(4'h0, 1'b1, 6'h2D, 1'b0, 1'b0);
      qacc(4'h0, 1'b1, 6'h2D, 1'b0, 1'b0);
      qacc(4'h0, 1'b1, 6'h2D, 1'b0, 1'b0);
      qacc(4'hD, 1'b1, 6'h1B, 1'b0, 1'b0);
      idle();
      check("no_lockout_cycles", cnt + locked_out, 0);
`endif

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      check("pending_responses", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
